fsk_modulator: RTL

Continuous-phase binary FSK modulator. It produces the 8-bit sine sample stream that the `detection` block consumes on its `A` input. Serial data bits are accepted through a valid/ready handshake. Each bit is emitted as `SAMPLES_PER_BIT` samples from a 360-entry sine cycle, using a phase step of `MARK_STEP` for a 1 and `SPACE_STEP` for a 0. Phase stays continuous across bit boundaries.

---
 rtl/fsk_modulator.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/fsk_modulator.sv
// Continuous-phase binary FSK modulator: streams 8-bit sine samples, SAMPLES_PER_BIT per data bit.
// Latency: first sample of a bit appears one edge after the bit is accepted; back-to-back bits leave no gap.
// Backpressure: bit_ready is high in IDLE and on the last sample of a bit. Optional bit_start port via FSK_MOD_BIT_START_EN.
module fsk_modulator #(
    parameter int SAMPLES_PER_BIT = 1500,
    parameter int MARK_STEP       = 2,
    parameter int SPACE_STEP      = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       bit_in,
    input  logic       bit_valid,
    output logic       bit_ready,
    output logic [7:0] A,
    output logic       sample_valid
`ifdef FSK_MOD_BIT_START_EN
    ,
    output logic       bit_start
`endif
);

    localparam int CNT_W = (SAMPLES_PER_BIT > 1) ? $clog2(SAMPLES_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(SAMPLES_PER_BIT - 1);
    localparam logic [8:0]       MARK_INC  = 9'(MARK_STEP);
    localparam logic [8:0]       SPACE_INC = 9'(SPACE_STEP);

    typedef enum logic {
        ST_IDLE,
        ST_SEND
    } state_t;

    state_t           state_q;
    logic [8:0]       phase_q;
    logic [CNT_W-1:0] samp_cnt_q;
    logic             cur_bit_q;
    logic [7:0]       a_q;
    logic             sample_valid_q;

    logic             xfer;
    logic             last_samp;
    logic [8:0]       step;
    logic [9:0]       phase_sum;
    logic [8:0]       phase_d;
    logic [6:0]       q_idx;
    logic             q_neg;
    logic [7:0]       q_val;
    logic [7:0]       sine_val;

    // First quadrant of 128 + round(127*sin(k deg)), k = 0..90, rounded half away from zero.
    function automatic logic [7:0] quarter_sine(input logic [6:0] k);
        logic [7:0] v;
        case (k)
            7'd0:  v = 8'd128;  7'd1:  v = 8'd130;  7'd2:  v = 8'd132;  7'd3:  v = 8'd135;
            7'd4:  v = 8'd137;  7'd5:  v = 8'd139;  7'd6:  v = 8'd141;  7'd7:  v = 8'd143;
            7'd8:  v = 8'd146;  7'd9:  v = 8'd148;  7'd10: v = 8'd150;  7'd11: v = 8'd152;
            7'd12: v = 8'd154;  7'd13: v = 8'd157;  7'd14: v = 8'd159;  7'd15: v = 8'd161;
            7'd16: v = 8'd163;  7'd17: v = 8'd165;  7'd18: v = 8'd167;  7'd19: v = 8'd169;
            7'd20: v = 8'd171;  7'd21: v = 8'd174;  7'd22: v = 8'd176;  7'd23: v = 8'd178;
            7'd24: v = 8'd180;  7'd25: v = 8'd182;  7'd26: v = 8'd184;  7'd27: v = 8'd186;
            7'd28: v = 8'd188;  7'd29: v = 8'd190;  7'd30: v = 8'd192;  7'd31: v = 8'd193;
            7'd32: v = 8'd195;  7'd33: v = 8'd197;  7'd34: v = 8'd199;  7'd35: v = 8'd201;
            7'd36: v = 8'd203;  7'd37: v = 8'd204;  7'd38: v = 8'd206;  7'd39: v = 8'd208;
            7'd40: v = 8'd210;  7'd41: v = 8'd211;  7'd42: v = 8'd213;  7'd43: v = 8'd215;
            7'd44: v = 8'd216;  7'd45: v = 8'd218;  7'd46: v = 8'd219;  7'd47: v = 8'd221;
            7'd48: v = 8'd222;  7'd49: v = 8'd224;  7'd50: v = 8'd225;  7'd51: v = 8'd227;
            7'd52: v = 8'd228;  7'd53: v = 8'd229;  7'd54: v = 8'd231;  7'd55: v = 8'd232;
            7'd56: v = 8'd233;  7'd57: v = 8'd235;  7'd58: v = 8'd236;  7'd59: v = 8'd237;
            7'd60: v = 8'd238;  7'd61: v = 8'd239;  7'd62: v = 8'd240;  7'd63: v = 8'd241;
            7'd64: v = 8'd242;  7'd65: v = 8'd243;  7'd66: v = 8'd244;  7'd67: v = 8'd245;
            7'd68: v = 8'd246;  7'd69: v = 8'd247;  7'd70: v = 8'd247;  7'd71: v = 8'd248;
            7'd72: v = 8'd249;  7'd73: v = 8'd249;  7'd74: v = 8'd250;  7'd75: v = 8'd251;
            7'd76: v = 8'd251;  7'd77: v = 8'd252;  7'd78: v = 8'd252;  7'd79: v = 8'd253;
            7'd80: v = 8'd253;  7'd81: v = 8'd253;  7'd82: v = 8'd254;  7'd83: v = 8'd254;
            7'd84: v = 8'd254;
            default: v = 8'd255;  // 85..90 all round to full scale
        endcase
        return v;
    endfunction

    // Ready only from registered state, so bit_valid never loops back into bit_ready.
    assign last_samp = (samp_cnt_q == LAST_CNT);
    assign bit_ready = (state_q == ST_IDLE) || ((state_q == ST_SEND) && last_samp);
    assign xfer      = bit_valid && bit_ready;

    // Phase accumulator: step sum is at most 718, so one conditional subtract wraps it.
    always_comb begin
        step      = cur_bit_q ? MARK_INC : SPACE_INC;
        phase_sum = {1'b0, phase_q} + {1'b0, step};
        phase_d   = phase_sum[8:0];
        if (phase_sum >= 10'd360) begin
            phase_d = 9'(phase_sum - 10'd360);
        end
    end

    // Fold the 360-entry cycle onto the quarter table; lower half is 256 minus the upper half.
    always_comb begin
        q_idx = 7'(phase_q);
        q_neg = 1'b0;
        if (phase_q <= 9'd90) begin
            q_idx = 7'(phase_q);
        end else if (phase_q <= 9'd179) begin
            q_idx = 7'(9'd180 - phase_q);
        end else if (phase_q <= 9'd270) begin
            q_idx = 7'(phase_q - 9'd180);
            q_neg = 1'b1;
        end else begin
            q_idx = 7'(9'd360 - phase_q);
            q_neg = 1'b1;
        end
        q_val    = quarter_sine(q_idx);
        // 256 - q fits in 8 bits because q >= 128; two's complement gives it directly.
        sine_val = q_neg ? (~q_val + 8'd1) : q_val;
    end

    // Control FSM with registered sample outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            phase_q        <= 9'd0;
            samp_cnt_q     <= '0;
            cur_bit_q      <= 1'b0;
            a_q            <= 8'd128;
            sample_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    a_q            <= 8'd128;
                    sample_valid_q <= 1'b0;
                    if (xfer) begin
                        state_q    <= ST_SEND;
                        cur_bit_q  <= bit_in;
                        samp_cnt_q <= '0;
                        phase_q    <= 9'd0;
                    end
                end
                ST_SEND: begin
                    a_q            <= sine_val;
                    sample_valid_q <= 1'b1;
                    phase_q        <= phase_d;
                    if (!last_samp) begin
                        samp_cnt_q <= samp_cnt_q + CNT_W'(1);
                    end else if (xfer) begin
                        // Back-to-back bit: phase carries on untouched for continuity.
                        cur_bit_q  <= bit_in;
                        samp_cnt_q <= '0;
                    end else begin
                        state_q    <= ST_IDLE;
                        samp_cnt_q <= '0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign A            = a_q;
    assign sample_valid = sample_valid_q;

`ifdef FSK_MOD_BIT_START_EN
    logic bit_start_q;

    // Mark the sample emitted while the counter sits at zero: the first sample of each bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_start_q <= 1'b0;
        end else begin
            bit_start_q <= (state_q == ST_SEND) && (samp_cnt_q == '0);
        end
    end

    assign bit_start = bit_start_q;
`endif

endmodule
